lt24_scan_sequencer: RTL and testbench

- Sequences the LT24 pixel write stream: walks an X/Y address pair across a full frame (column-fastest, row-slowest).
- Issues one pixel-write request per address under a valid/ready handshake with the LT24 write interface.
- Supports single-shot or continuous frames, with a counted blanking gap between frames.
- Sits between the display top level and the LT24 driver; replaces free-running counters with a start/stop-controlled scheduler.

---
 rtl/lt24_scan_sequencer.sv | 132 +++++++++++++
 tb/tb_lt24_scan_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_scan_sequencer.sv
// LT24 pixel-write scan sequencer.
// Walks (xAddr, yAddr) across one frame, column-fastest, issuing one
// pixel-write request per address under a valid/ready handshake. Frames run
// once or back-to-back, separated by a counted blanking gap.
//
// state | meaning
// IDLE  | no frame in progress, pixelWrite low, waiting for start
// SCAN  | pixelWrite high, address advances on each accepted pixel
// GAP   | blanking between continuous frames, pixelWrite low
module lt24_scan_sequencer #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 9,
    parameter int X_MAX      = 239,
    parameter int Y_MAX      = 319,
    parameter int GAP_CYCLES = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    input  logic               pixelReady,
    output logic               pixelWrite,
    output logic [X_WIDTH-1:0] xAddr,
    output logic [Y_WIDTH-1:0] yAddr,
    output logic               busy,
    output logic               frameDone,
    output logic [7:0]         frameCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [X_WIDTH-1:0]   X_LAST   = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0]   Y_LAST   = Y_WIDTH'(Y_MAX);
    // With no gap the counter is never used; keep the constant legal anyway.
    localparam logic [GAP_WIDTH-1:0] GAP_LAST = GAP_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]           state;
    logic                 stop_pending;
    logic [GAP_WIDTH-1:0] gap_count;
    logic                 handshake;
    logic                 keep_going;

    // A pixel is accepted when the request and the driver's ready coincide.
    always_comb begin
        handshake  = pixelWrite & pixelReady;
        keep_going = continuous & ~stop_pending & ~stop;
    end

    // Frame scheduler: state, address walk, gap timing and frame bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            gap_count    <= '0;
            pixelWrite   <= 1'b0;
            xAddr        <= '0;
            yAddr        <= '0;
            busy         <= 1'b0;
            frameDone    <= 1'b0;
            frameCount   <= 8'd0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_SCAN;
                        pixelWrite   <= 1'b1;
                        busy         <= 1'b1;
                        xAddr        <= '0;
                        yAddr        <= '0;
                        // A stop arriving with start still lets one frame run.
                        stop_pending <= stop;
                    end
                end
                S_SCAN: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (handshake) begin
                        if (xAddr < X_LAST) begin
                            xAddr <= xAddr + 1'b1;
                        end else if (yAddr < Y_LAST) begin
                            xAddr <= '0;
                            yAddr <= yAddr + 1'b1;
                        end else begin
                            xAddr      <= '0;
                            yAddr      <= '0;
                            frameDone  <= 1'b1;
                            frameCount <= frameCount + 8'd1;
                            if (keep_going) begin
                                // Zero gap: stay in SCAN so (0,0) follows the last pixel directly.
                                if (GAP_CYCLES > 0) begin
                                    state      <= S_GAP;
                                    pixelWrite <= 1'b0;
                                    gap_count  <= '0;
                                end
                            end else begin
                                state        <= S_IDLE;
                                pixelWrite   <= 1'b0;
                                busy         <= 1'b0;
                                stop_pending <= 1'b0;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (gap_count == GAP_LAST) begin
                        state      <= S_SCAN;
                        pixelWrite <= 1'b1;
                    end else begin
                        gap_count <= gap_count + 1'b1;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    pixelWrite   <= 1'b0;
                    busy         <= 1'b0;
                    stop_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lt24_scan_sequencer.sv
// Bench for lt24_scan_sequencer: three instances share one stimulus stream
// (4x3 frame with a 2-cycle gap, 4x3 frame with no gap, 1x1 frame with no gap)
// and are compared every cycle against a frame-level reference model.
module tb_lt24_scan_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1, start = 1'b0, continuous = 1'b0, stop = 1'b0, pixelReady = 1'b0;

    logic [2:0] pw, bsy, fd;
    logic [1:0] x0, y0, x1, y1;
    logic       x2, y2;
    logic [7:0] fc0, fc1, fc2;

    lt24_scan_sequencer #(.X_WIDTH(2), .Y_WIDTH(2), .X_MAX(3), .Y_MAX(2), .GAP_CYCLES(2), .GAP_WIDTH(8)) u0 (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
        .pixelReady(pixelReady), .pixelWrite(pw[0]), .xAddr(x0), .yAddr(y0), .busy(bsy[0]),
        .frameDone(fd[0]), .frameCount(fc0));

    lt24_scan_sequencer #(.X_WIDTH(2), .Y_WIDTH(2), .X_MAX(3), .Y_MAX(2), .GAP_CYCLES(0), .GAP_WIDTH(8)) u1 (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
        .pixelReady(pixelReady), .pixelWrite(pw[1]), .xAddr(x1), .yAddr(y1), .busy(bsy[1]),
        .frameDone(fd[1]), .frameCount(fc1));

    lt24_scan_sequencer #(.X_WIDTH(1), .Y_WIDTH(1), .X_MAX(0), .Y_MAX(0), .GAP_CYCLES(0), .GAP_WIDTH(8)) u2 (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
        .pixelReady(pixelReady), .pixelWrite(pw[2]), .xAddr(x2), .yAddr(y2), .busy(bsy[2]),
        .frameDone(fd[2]), .frameCount(fc2));

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference model: mode 0 idle, 1 scanning, 2 blanking; pixel index within frame.
    int XM[3] = '{3, 3, 0};
    int YM[3] = '{2, 2, 0};
    int GP[3] = '{2, 0, 0};
    int m_mode[3], m_pix[3], m_g[3], m_fc[3];
    bit m_stop[3], m_done[3];
    bit m_valid = 1'b0;

    function automatic void model_step(int k);
        int  n;
        bit  stop_before;
        n = (XM[k] + 1) * (YM[k] + 1);
        if (reset) begin
            m_mode[k] = 0; m_pix[k] = 0; m_g[k] = 0; m_fc[k] = 0; m_stop[k] = 0; m_done[k] = 0;
            return;
        end
        m_done[k] = 0;
        case (m_mode[k])
            0: if (start) begin
                m_mode[k] = 1; m_pix[k] = 0; m_stop[k] = stop;
            end
            1: begin
                stop_before = m_stop[k];
                if (stop) m_stop[k] = 1;
                if (pixelReady) begin
                    if (m_pix[k] == n - 1) begin
                        m_pix[k] = 0; m_done[k] = 1; m_fc[k]++;
                        if (continuous && !stop_before && !stop) begin
                            if (GP[k] > 0) begin m_mode[k] = 2; m_g[k] = 1; end
                        end else begin
                            m_mode[k] = 0; m_stop[k] = 0;
                        end
                    end else begin
                        m_pix[k]++;
                    end
                end
            end
            default: begin
                if (stop) begin m_mode[k] = 0; m_stop[k] = 0; end
                else if (m_g[k] == GP[k]) begin m_mode[k] = 1; m_pix[k] = 0; end
                else m_g[k]++;
            end
        endcase
    endfunction

    // Monitor state for DUT u0/u1/u2 derived observations.
    int  hs_q[$];
    int  gap_q[$];
    int  run0 = 0, done0 = 0, done2 = 0, nogap1 = 0;
    bit  prev_pw0 = 1'b0;
    int  prev_x0 = 0, prev_y0 = 0;
    int  ax[3], ay[3];

    // Advance the model on the inputs just sampled, then compare every output.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) model_step(k);
        if (reset) m_valid = 1'b1;
        if (m_valid) begin
            ax[0] = int'(x0); ay[0] = int'(y0);
            ax[1] = int'(x1); ay[1] = int'(y1);
            ax[2] = int'(x2); ay[2] = int'(y2);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d.pixelWrite", k), int'(pw[k]), int'(m_mode[k] == 1));
                check($sformatf("u%0d.busy", k), int'(bsy[k]), int'(m_mode[k] != 0));
                check($sformatf("u%0d.frameDone", k), int'(fd[k]), int'(m_done[k]));
                check($sformatf("u%0d.xAddr", k), ax[k], m_pix[k] % (XM[k] + 1));
                check($sformatf("u%0d.yAddr", k), ay[k], m_pix[k] / (XM[k] + 1));
            end
            check("u0.frameCount", int'(fc0), m_fc[0] % 256);
            check("u1.frameCount", int'(fc1), m_fc[1] % 256);
            check("u2.frameCount", int'(fc2), m_fc[2] % 256);
        end
        if (!reset && prev_pw0 && pixelReady) hs_q.push_back(prev_x0 * 100 + prev_y0);
        if (bsy[0] === 1'b1 && pw[0] === 1'b0) run0++;
        else if (run0 > 0) begin gap_q.push_back(run0); run0 = 0; end
        if (fd[0] === 1'b1) done0++;
        if (fd[2] === 1'b1) done2++;
        if (bsy[1] === 1'b1 && pw[1] === 1'b0) nogap1++;
        prev_pw0 = (pw[0] === 1'b1);
        prev_x0  = int'(x0);
        prev_y0  = int'(y0);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (bsy != 3'b000 && c < budget) begin step(); c++; end
        check("wait_idle", int'(bsy), 0);
    endtask

    task automatic check_order();
        check("hs_count", hs_q.size(), 12);
        for (int y = 0; y <= 2; y++)
            for (int x = 0; x <= 3; x++)
                check("hs_order", (y * 4 + x < hs_q.size()) ? hs_q[y * 4 + x] : -1, x * 100 + y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  d0, d2, ng, c;
        bit  hit;

        // Reset state
        step(); step();
        check("rst.pixelWrite", int'(pw), 0);
        check("rst.busy", int'(bsy), 0);
        check("rst.frameDone", int'(fd), 0);
        check("rst.frameCount", int'(fc0), 0);
        check("rst.addr", int'({x0, y0}), 0);
        reset = 1'b0;
        step();

        // Single frame, ready tied high
        pixelReady = 1'b1; continuous = 1'b0;
        hs_q.delete(); d0 = done0;
        start = 1'b1; step(); start = 1'b0;
        wait_idle(100);
        check("s1.frameCount", int'(fc0), 1);
        check("s1.frameDone_pulses", done0 - d0, 1);
        check_order();
        check("s1.pixel4", (hs_q.size() > 4) ? hs_q[4] : -1, 1);
        check("s1.last", (hs_q.size() > 11) ? hs_q[11] : -1, 302);

        // Single frame with ready pattern 1,0,0 repeating
        hs_q.delete();
        start = 1'b1; step(); start = 1'b0;
        c = 0;
        while (bsy != 3'b000 && c < 300) begin
            pixelReady = (c % 3 == 0);
            step(); c++;
        end
        check("s2.idle", int'(bsy), 0);
        check("s2.frameCount", int'(fc0), 2);
        check_order();

        // Continuous frames, random ready, stop in the middle of frame 3
        gap_q.delete(); ng = nogap1; hit = 1'b0;
        continuous = 1'b1; pixelReady = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        c = 0;
        while (c < 3000) begin
            pixelReady = ($urandom_range(0, 3) != 0);
            if (!hit && fc0 == 8'd4 && y0 == 2'd1 && pw[0]) begin stop = 1'b1; hit = 1'b1; end
            else stop = 1'b0;
            step(); c++;
            if (bsy == 3'b000) break;
        end
        stop = 1'b0; continuous = 1'b0; pixelReady = 1'b1;
        check("s3.stop_issued", int'(hit), 1);
        check("s3.idle", int'(bsy), 0);
        check("s3.frameCount", int'(fc0), 5);
        check("s3.gap_count", gap_q.size(), 2);
        check("s3.gap0_len", (gap_q.size() > 0) ? gap_q[0] : -1, 2);
        check("s3.gap1_len", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
        check("s3.nogap_drops", nogap1 - ng, 0);

        // Start while busy is ignored
        hs_q.delete();
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        start = 1'b1; step(); start = 1'b0;
        wait_idle(100);
        check("s4.frameCount", int'(fc0), 6);
        check_order();

        // Simultaneous start and stop in IDLE: exactly one frame
        d0 = done0;
        continuous = 1'b1; start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        wait_idle(100);
        continuous = 1'b0;
        check("s5.frameCount", int'(fc0), 7);
        check("s5.frameDone_pulses", done0 - d0, 1);

        // Reset in the middle of a frame at (2,1)
        start = 1'b1; step(); start = 1'b0;
        c = 0;
        while (!(x0 == 2'd2 && y0 == 2'd1) && c < 50) begin step(); c++; end
        check("s6.reached_2_1", int'({x0, y0}), int'({2'd2, 2'd1}));
        reset = 1'b1; step(); reset = 1'b0;
        check("s6.pixelWrite", int'(pw), 0);
        check("s6.busy", int'(bsy), 0);
        check("s6.frameDone", int'(fd), 0);
        check("s6.addr", int'({x0, y0}), 0);
        check("s6.frameCount", int'(fc0), 0);
        step();

        // 256 frames on the 1x1 instance: frameCount wraps to 0
        d2 = done2;
        continuous = 1'b1; pixelReady = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        c = 0;
        while (done2 - d2 < 256 && c < 1000) begin step(); c++; end
        check("s7.done_pulses", done2 - d2, 256);
        check("s7.frameCount_wrap", int'(fc2), 0);
        stop = 1'b1; step(); stop = 1'b0;
        wait_idle(200);
        continuous = 1'b0;

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 31) == 0);
            pixelReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) continuous = ~continuous;
            reset      = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b1; pixelReady = 1'b1;
        step(); stop = 1'b0;
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
